// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared states, 50 MHz timing defaults and counter widths for the WS2812 transmitter
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    localparam int ADDR_WIDTH_DEF = 9;
    localparam int T0H_DEF        = 20;
    localparam int T1H_DEF        = 40;
    localparam int TBIT_DEF       = 63;
    localparam int TRESET_DEF     = 15000;

    // A counter running 0..n-1 needs $clog2(n) bits, but never fewer than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int TCNT_W_DEF = cnt_width(TBIT_DEF);
    localparam int LCNT_W_DEF = cnt_width(TRESET_DEF);

endpackage

// File: rtl/ws2812_bit_timer.sv
// rtl/ws2812_bit_timer.sv - per-bit cycle counter and registered high/low waveform for one WS2812 bit
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H    = T0H_DEF,
    parameter int T1H    = T1H_DEF,
    parameter int TBIT   = TBIT_DEF,
    parameter int TCNT_W = TCNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic out_en_i,
    input  logic bit_i,
    output logic bit_end_o,
    output logic ws_o
);

    localparam logic [TCNT_W-1:0] LAST_C = TCNT_W'(TBIT - 1);
    localparam logic [TCNT_W-1:0] T0H_C  = TCNT_W'(T0H);
    localparam logic [TCNT_W-1:0] T1H_C  = TCNT_W'(T1H);
    localparam logic [TCNT_W-1:0] ONE_C  = TCNT_W'(1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              ws_q, ws_d;

    // The output is registered from next-cycle values so the line toggles exactly on bit boundaries.
    always_comb begin
        bit_end_o = run_i && (tcnt_q == LAST_C);
        tcnt_d    = '0;
        if (run_i && !bit_end_o) begin
            tcnt_d = tcnt_q + ONE_C;
        end
        ws_d = out_en_i && (tcnt_d < (bit_i ? T1H_C : T0H_C));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            ws_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            ws_q   <= ws_d;
        end
    end

    assign ws_o = ws_q;

endmodule

// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - streams num_bytes RAM bytes MSB-first as a WS2812 waveform followed by a latch period
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int T0H        = T0H_DEF,
    parameter int T1H        = T1H_DEF,
    parameter int TBIT       = TBIT_DEF,
    parameter int TRESET     = TRESET_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_bytes,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [7:0]            rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  ws_out
);

    localparam int TW = (TBIT == TBIT_DEF) ? TCNT_W_DEF : cnt_width(TBIT);
    localparam int LW = (TRESET == TRESET_DEF) ? LCNT_W_DEF : cnt_width(TRESET);

    localparam logic [LW-1:0]         LAST_L    = LW'(TRESET - 1);
    localparam logic [LW-1:0]         ONE_L     = LW'(1);
    localparam logic [ADDR_WIDTH:0]   MAX_BYTES = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   ONE_B     = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH:0]   byte_cnt_q, byte_cnt_d;
    logic [LW-1:0]         lcnt_q, lcnt_d;
    logic                  bit_end;

    // byte_cnt counts bytes still to be loaded into the shifter, so zero means the current byte is the last.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        raddr_d    = raddr_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        lcnt_d     = '0;

        unique case (state_q)
            ST_IDLE: begin
                raddr_d = '0;
                if (start) begin
                    if (num_bytes == '0) begin
                        done_d = 1'b1;
                    end else begin
                        byte_cnt_d = (num_bytes > MAX_BYTES) ? MAX_BYTES : num_bytes;
                        busy_d     = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                shift_d    = rdata;
                raddr_d    = ONE_A;
                bit_cnt_d  = 3'd7;
                byte_cnt_d = byte_cnt_q - ONE_B;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (bit_end) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        if (byte_cnt_q != '0) begin
                            shift_d    = rdata;
                            bit_cnt_d  = 3'd7;
                            byte_cnt_d = byte_cnt_q - ONE_B;
                            // Only prefetch when another byte will follow; keeps raddr below 2^ADDR_WIDTH.
                            if (byte_cnt_q > ONE_B) begin
                                raddr_d = raddr_q + ONE_A;
                            end
                        end else begin
                            state_d = ST_LATCH;
                        end
                    end
                end
            end
            ST_LATCH: begin
                lcnt_d = lcnt_q + ONE_L;
                if (lcnt_q == LAST_L) begin
                    lcnt_d  = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            raddr_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            lcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            raddr_q    <= raddr_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            lcnt_q     <= lcnt_d;
        end
    end

    ws2812_bit_timer #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TCNT_W (TW)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (state_q == ST_SEND),
        .out_en_i  (state_d == ST_SEND),
        .bit_i     (shift_d[7]),
        .bit_end_o (bit_end),
        .ws_o      (ws_out)
    );

    assign raddr = raddr_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// tb/tb_ws2812_tx.sv - self-checking bench for ws2812_tx with a RAM model and a waveform reference model
module tb_ws2812_tx;

    localparam int AW     = 9;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TRESET = 10;
    localparam int LIMIT  = 30000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   num_bytes;
    logic [AW-1:0] raddr;
    logic [7:0]    rdata = 8'h00;
    logic          busy;
    logic          done;
    logic          ws_out;

    logic [7:0] mem [512];

    int tests = 0;
    int fails = 0;

    bit cap_ws[$];
    bit cap_busy[$];
    bit exp_ws[$];
    int got_done_idx;
    int done_cnt;
    int raddr_max;
    int raddr_zero;

    typedef struct {
        int nb;
        int pattern;
        int restart_at;
        int exp_done;
        int exp_rmax;
        int exp_sent;
    } vec_t;

    vec_t vecs[6];

    ws2812_tx #(
        .ADDR_WIDTH (AW),
        .T0H        (T0H),
        .T1H        (T1H),
        .TBIT       (TBIT),
        .TRESET     (TRESET)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_bytes (num_bytes),
        .raddr     (raddr),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .ws_out    (ws_out)
    );

    always #5 clk = ~clk;

    // RAM read port registers on the falling edge.
    always @(negedge clk) rdata <= mem[raddr];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pattern(input int p);
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        if (p == 1) begin
            mem[0] = 8'hA5;
        end else if (p == 2) begin
            mem[0] = 8'hFF;
            mem[1] = 8'h00;
            mem[2] = 8'h81;
        end
    endtask

    task automatic build_model(input int n);
        logic [7:0] b;
        int hi;
        exp_ws.delete();
        exp_ws.push_back(1'b0);
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                b = mem[i];
                for (int j = 7; j >= 0; j--) begin
                    hi = b[j] ? T1H : T0H;
                    for (int t = 0; t < TBIT; t++) exp_ws.push_back(t < hi);
                end
            end
            for (int t = 0; t <= TRESET; t++) exp_ws.push_back(1'b0);
        end
    endtask

    task automatic run_frame(input int nb, input int restart_at);
        int k;
        int extra;
        cap_ws.delete();
        cap_busy.delete();
        got_done_idx = -1;
        done_cnt = 0;
        raddr_max = 0;
        raddr_zero = 0;
        extra = 0;
        k = 0;
        @(negedge clk);
        start = 1'b1;
        num_bytes = (AW + 1)'(nb);
        @(negedge clk);
        start = 1'b0;
        num_bytes = (AW + 1)'($urandom);
        while (k < LIMIT) begin
            cap_ws.push_back(ws_out);
            cap_busy.push_back(busy);
            if (int'(raddr) > raddr_max) raddr_max = int'(raddr);
            if (k >= 1 && got_done_idx < 0 && nb > 0 && raddr == '0) raddr_zero++;
            if (done) begin
                done_cnt++;
                if (got_done_idx < 0) got_done_idx = k;
            end
            if (got_done_idx >= 0) begin
                extra++;
                if (extra > 4) break;
            end
            start = (k == restart_at);
            if (k == restart_at) num_bytes = (AW + 1)'(5);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        if (got_done_idx < 0) check("done_timeout", 0, 1);
    endtask

    task automatic compare_frame(input string pfx, input int n, input int exp_done, input int exp_rmax);
        int ws_err;
        int busy_err;
        bit e;
        bit eb;
        ws_err = 0;
        busy_err = 0;
        build_model(n);
        for (int k = 0; k < cap_ws.size(); k++) begin
            e  = (k < exp_ws.size()) ? exp_ws[k] : 1'b0;
            eb = (n > 0) && (k < exp_done);
            if (cap_ws[k] != e) ws_err++;
            if (cap_busy[k] != eb) busy_err++;
        end
        check($sformatf("%s_done_idx", pfx), got_done_idx, exp_done);
        check($sformatf("%s_done_cnt", pfx), done_cnt, 1);
        check($sformatf("%s_ws_err", pfx), ws_err, 0);
        check($sformatf("%s_busy_err", pfx), busy_err, 0);
        check($sformatf("%s_raddr_max", pfx), raddr_max, exp_rmax);
        check($sformatf("%s_raddr_zero", pfx), raddr_zero, 0);
    endtask

    initial begin
        int nb;
        int runs;
        int exp_runs[8];

        vecs[0] = '{nb: 1,   pattern: 1, restart_at: -1, exp_done: 59,    exp_rmax: 1,   exp_sent: 1};
        vecs[1] = '{nb: 3,   pattern: 2, restart_at: -1, exp_done: 155,   exp_rmax: 2,   exp_sent: 3};
        vecs[2] = '{nb: 0,   pattern: 0, restart_at: -1, exp_done: 0,     exp_rmax: 0,   exp_sent: 0};
        vecs[3] = '{nb: 2,   pattern: 0, restart_at: 20, exp_done: 107,   exp_rmax: 1,   exp_sent: 2};
        vecs[4] = '{nb: 600, pattern: 0, restart_at: -1, exp_done: 24587, exp_rmax: 511, exp_sent: 512};
        vecs[5] = '{nb: 5,   pattern: 0, restart_at: -1, exp_done: 251,   exp_rmax: 4,   exp_sent: 5};
        exp_runs = '{4, 2, 4, 2, 2, 4, 2, 4};

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        start = 1'b0;
        num_bytes = '0;
        repeat (3) @(negedge clk);
        check("rst_ws", ws_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_raddr", raddr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ws", ws_out, 0);
        check("idle_busy", busy, 0);

        for (int v = 0; v < 6; v++) begin
            set_pattern(vecs[v].pattern);
            run_frame(vecs[v].nb, vecs[v].restart_at);
            compare_frame($sformatf("vec%0d", v), vecs[v].exp_sent, vecs[v].exp_done, vecs[v].exp_rmax);
            if (vecs[v].pattern == 1) begin
                for (int b = 0; b < 8; b++) begin
                    runs = 0;
                    for (int t = 0; t < TBIT; t++) runs += int'(cap_ws[1 + b * TBIT + t]);
                    check($sformatf("a5_run%0d", b), runs, exp_runs[b]);
                end
            end
        end

        for (int r = 0; r < 4; r++) begin
            nb = int'($urandom_range(1, 8));
            set_pattern(0);
            run_frame(nb, -1);
            compare_frame($sformatf("rand%0d", r), nb, 1 + nb * 8 * TBIT + TRESET, (nb > 1) ? nb - 1 : 1);
        end

        // Abort a 3-byte frame while the first bit of byte 1 is high.
        set_pattern(2);
        @(negedge clk);
        start = 1'b1;
        num_bytes = (AW + 1)'(3);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check("abort_pre_ws", ws_out, 1);
        check("abort_pre_raddr", raddr, 2);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ws", ws_out, 0);
        check("abort_busy", busy, 0);
        check("abort_raddr", raddr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done || busy || ws_out) done_cnt++;
        end
        check("abort_quiet", done_cnt, 0);
        run_frame(3, -1);
        compare_frame("after_abort", 3, 155, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
